dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the single-port `data_memory`. It shares the memory between the core load/store unit (port 0) and a secondary master such as a program loader, DMA or debug unit (port 1). It accepts one request at a time over valid/ready, drives the memory's write-enable, address, write-data and size-mode inputs for exactly one access cycle, and returns read data plus an alignment-error flag through a registered valid/ready response channel.

## Interface
- `ADDR_W`, default 32: address width of requests and `mem_addr_o`.
- `DATA_W`, default 32: data width of read and write data.

Ports:
- `clk_i` in 1: clock; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `reqN_valid_i` in 1 (N=0,1): request valid.
- `reqN_ready_o` out 1: request accepted this cycle.
- `reqN_we_i` in 1: 1 = store, 0 = load.
- `reqN_mode_i` in 2: access size. 00 byte, 01 halfword, 10 word, 11 illegal.
- `reqN_addr_i` in ADDR_W: byte address.
- `reqN_wdata_i` in DATA_W: store data.
- `rspN_valid_o` out 1: response valid.
- `rspN_ready_i` in 1: response consumed.
- `rspN_rdata_o` out DATA_W: load data; 0 for stores and errored requests.
- `rspN_err_o` out 1: misaligned address or illegal mode.
- `mem_we_o` out 1: memory write enable.
- `mem_wdata_o` out DATA_W: memory write data.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_mode_o` out 2: memory size mode.
- `mem_rdata_i` in DATA_W: memory read data, combinational from `mem_addr_o`/`mem_mode_o`.

## Operation
- FSM states:
  - IDLE: no transaction held.
    - Arbitrate among the asserted `reqN_valid_i`.
    - Assert `reqN_ready_o` for the winner only, combinationally.
    - The handshake latches `we`, `mode`, `addr` and `wdata`, records the port, and moves to ACCESS.
  - ACCESS: exactly one cycle.
    - Drive `mem_addr_o`, `mem_mode_o` and `mem_wdata_o` from the latched request.
    - `mem_we_o` = latched `we` AND NOT err.
    - At the clock edge, capture `mem_rdata_i`; the captured value is 0 if `we` or err. Capture err. Go to RESP.
  - RESP: assert `rspN_valid_o` for the recorded port only.
    - Hold rdata and err stable until `rspN_ready_i`, then go to IDLE.
- err conditions:
  - mode 11.
  - mode 01 with addr[0]=1.
  - mode 10 with addr[1:0]≠00.
  - Byte accesses never error.
- An errored store never writes: `mem_we_o` stays 0 for that access.
- Outside ACCESS, all `mem_*` outputs are 0.
- Arbitration for simultaneous valids:
  - A `last_grant` register is updated on each accept.
  - With both valids asserted, the port that did not win last is granted.
  - With one valid asserted, that port is granted.
- At most one transaction is outstanding. Both `reqN_ready_o` are 0 in ACCESS and RESP.
- A requester may drop valid before it is accepted. There is no penalty and no state change.

## Timing
- Reset (`rst_i`=0) forces, immediately and asynchronously:
  - state = IDLE, `last_grant` = 1 so port 0 wins the first tie.
  - All outputs 0, including `mem_we_o`.
  - Any in-flight request is dropped with no response. A reset during ACCESS suppresses the write.
- Latency:
  - Request accepted at edge E.
  - Memory access during cycle E..E+1; a store commits at edge E+1.
  - `rspN_valid_o` high from E+1.
  - With `rspN_ready_i` held 1, the response completes at edge E+2. The next accept is possible at edge E+3.
- Throughput: one access per 3 cycles maximum.
- A response with `rspN_ready_i` held low stalls indefinitely. No new requests are accepted while it is pending.

## Configuration
- `DMEM_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration as described above.
- `DMEM_ARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority; port 0 always wins ties.
  - `last_grant` is not implemented.
  - Port 1 is granted only when `req0_valid_i`=0 in IDLE.

## Test plan
- Port 0 store, word mode, addr 0x4, data 0x01C00F93 -> `mem_we_o`=1 for one cycle with addr 0x4 and mode 10. rsp0 valid at E+1 with err=0 and rdata=0.
- Port 1 load, word mode, addr 0x4 after that store -> `rsp1_rdata_o`=0x01C00F93. Byte load at 0x4 -> 0x00000093 (sign/zero extension per `data_memory`). Halfword load -> 0x00000F93.
- Port 0 word store at addr 0x1 with data 0x000F8083 -> `rsp0_err_o`=1 and `mem_we_o` never asserted. A subsequent word load at 0x4 still returns 0x01C00F93.
- Both ports request continuously:
  - With `DMEM_ARB_ROUND_ROBIN_EN` defined -> grants alternate 0,1,0,1.
  - Undefined -> port 0 granted every time and port 1 is starved.
- `rsp0_ready_i` held 0 for 5 cycles -> `rsp0_valid_o`, rdata and err stay constant. `req1_ready_o` stays 0 throughout. Accept occurs the cycle after release.
- Assert `rst_i`=0 mid-ACCESS of a store -> `mem_we_o` drops immediately, the location is unchanged, and no response is issued. After release the FSM is in IDLE and port 0 wins a tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port valid/ready arbiter and one-cycle sequencer in front of the single-port data_memory.
// Optional: define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to port 0.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic              req0_we_i,
  input  logic [1:0]        req0_mode_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              rsp0_valid_o,
  input  logic              rsp0_ready_i,
  output logic [DATA_W-1:0] rsp0_rdata_o,
  output logic              rsp0_err_o,

  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic              req1_we_i,
  input  logic [1:0]        req1_mode_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              rsp1_valid_o,
  input  logic              rsp1_ready_i,
  output logic [DATA_W-1:0] rsp1_rdata_o,
  output logic              rsp1_err_o,

  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_mode_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic              port_q;
  logic              lat_we;
  logic [1:0]        lat_mode;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic any_valid;
  logic grant;
  logic acc_err;

  assign any_valid = req0_valid_i | req1_valid_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    if (req0_valid_i && req1_valid_i) grant = ~last_grant;
    else                              grant = ~req0_valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                          last_grant <= 1'b1;
    else if (state == S_IDLE && any_valid) last_grant <= grant;
  end
`else
  always_comb grant = ~req0_valid_i;
`endif

  always_comb begin
    case (lat_mode)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = lat_addr[0];
      2'b10:   acc_err = |lat_addr[1:0];
      default: acc_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    rsp0_rdata_o = '0;
    rsp1_rdata_o = '0;
    rsp0_err_o   = 1'b0;
    rsp1_err_o   = 1'b0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = '0;
    mem_addr_o   = '0;
    mem_mode_o   = '0;
    case (state)
      S_IDLE: begin
        if (any_valid) begin
          req0_ready_o = ~grant;
          req1_ready_o = grant;
          state_nxt    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        mem_we_o    = lat_we & ~acc_err;
        mem_wdata_o = lat_wdata;
        mem_addr_o  = lat_addr;
        mem_mode_o  = lat_mode;
        state_nxt   = S_RESP;
      end
      S_RESP: begin
        if (port_q) begin
          rsp1_valid_o = 1'b1;
          rsp1_rdata_o = rsp_rdata_q;
          rsp1_err_o   = rsp_err_q;
          if (rsp1_ready_i) state_nxt = S_IDLE;
        end else begin
          rsp0_valid_o = 1'b1;
          rsp0_rdata_o = rsp_rdata_q;
          rsp0_err_o   = rsp_err_q;
          if (rsp0_ready_i) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      port_q      <= 1'b0;
      lat_we      <= 1'b0;
      lat_mode    <= '0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && any_valid) begin
        port_q    <= grant;
        lat_we    <= grant ? req1_we_i    : req0_we_i;
        lat_mode  <= grant ? req1_mode_i  : req0_mode_i;
        lat_addr  <= grant ? req1_addr_i  : req0_addr_i;
        lat_wdata <= grant ? req1_wdata_i : req0_wdata_i;
      end
      if (state == S_ACCESS) begin
        rsp_rdata_q <= (lat_we || acc_err) ? '0 : mem_rdata_i;
        rsp_err_q   <= acc_err;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed little-endian memory stub.
// Expected arbitration order follows DMEM_ARB_ROUND_ROBIN_EN.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]  req_valid, req_we, rsp_ready;
  logic [1:0]  req_mode [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata[2];

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic [1:0]  mem_mode;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req0_valid_i(req_valid[0]), .req0_ready_o(req0_ready), .req0_we_i(req_we[0]),
    .req0_mode_i(req_mode[0]), .req0_addr_i(req_addr[0]), .req0_wdata_i(req_wdata[0]),
    .rsp0_valid_o(rsp0_valid), .rsp0_ready_i(rsp_ready[0]), .rsp0_rdata_o(rsp0_rdata),
    .rsp0_err_o(rsp0_err),
    .req1_valid_i(req_valid[1]), .req1_ready_o(req1_ready), .req1_we_i(req_we[1]),
    .req1_mode_i(req_mode[1]), .req1_addr_i(req_addr[1]), .req1_wdata_i(req_wdata[1]),
    .rsp1_valid_o(rsp1_valid), .rsp1_ready_i(rsp_ready[1]), .rsp1_rdata_o(rsp1_rdata),
    .rsp1_err_o(rsp1_err),
    .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_addr_o(mem_addr),
    .mem_mode_o(mem_mode), .mem_rdata_i(mem_rdata)
  );

  // Memory stub: zero-extending combinational read, write on the rising edge.
  logic [7:0] mem [256];
  logic [7:0] ma;
  assign ma = mem_addr[7:0];
  always_comb begin
    case (mem_mode)
      2'b00:   mem_rdata = {24'h0, mem[ma]};
      2'b01:   mem_rdata = {16'h0, mem[ma + 8'd1], mem[ma]};
      default: mem_rdata = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
    endcase
  end
  always @(posedge clk) begin
    if (mem_we) begin
      mem[ma] <= mem_wdata[7:0];
      if (mem_mode != 2'b00) mem[ma + 8'd1] <= mem_wdata[15:8];
      if (mem_mode == 2'b10) begin
        mem[ma + 8'd2] <= mem_wdata[23:16];
        mem[ma + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 1) ? req1_ready : req0_ready;
  endfunction

  task automatic drive(input int p, input logic we, input logic [1:0] mode,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_mode[p]  = mode;
    req_addr[p]  = addr;
    req_wdata[p] = wdata;
  endtask

  // Bounded wait (at negedge+1) for a port's ready; returns 1 if seen.
  task automatic wait_ready(input int p, output bit seen);
    int cyc = 0;
    #1;
    while (!rdy(p) && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    seen = rdy(p);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic run_txn(input vec_t v, input int idx);
    bit seen;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    drive(v.port, v.we, v.mode, v.addr, v.wdata);
    wait_ready(v.port, seen);
    check({tag, "_ready"}, 32'(seen), 32'd1);
    if (!seen) begin
      req_valid[v.port] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[v.port] = 1'b0;
    check({tag, "_mem_we"},   32'(mem_we), 32'(v.we & ~v.err));
    check({tag, "_mem_addr"}, mem_addr, v.addr);
    check({tag, "_mem_mode"}, 32'(mem_mode), 32'(v.mode));
    check({tag, "_early_rsp"}, 32'(rsp0_valid | rsp1_valid), 32'd0);
    @(negedge clk);
    check({tag, "_rsp_valid"}, 32'({rsp1_valid, rsp0_valid}), (v.port == 1) ? 32'd2 : 32'd1);
    check({tag, "_rdata"}, (v.port == 1) ? rsp1_rdata : rsp0_rdata, v.rdata);
    check({tag, "_err"},   32'((v.port == 1) ? rsp1_err : rsp0_err), 32'(v.err));
    check({tag, "_mem_idle"}, 32'(mem_we) | mem_addr, 32'd0);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int g, prev;
    logic exp_g[4];

    vecs[0]  = '{0, 1'b1, 2'b10, 32'h4, 32'h01C00F93, 32'h0,        1'b0};
    vecs[1]  = '{1, 1'b0, 2'b10, 32'h4, 32'h0,        32'h01C00F93, 1'b0};
    vecs[2]  = '{1, 1'b0, 2'b00, 32'h4, 32'h0,        32'h00000093, 1'b0};
    vecs[3]  = '{1, 1'b0, 2'b01, 32'h4, 32'h0,        32'h00000F93, 1'b0};
    vecs[4]  = '{0, 1'b1, 2'b10, 32'h1, 32'h000F8083, 32'h0,        1'b1};
    vecs[5]  = '{0, 1'b0, 2'b10, 32'h4, 32'h0,        32'h01C00F93, 1'b0};
    vecs[6]  = '{1, 1'b0, 2'b00, 32'h1, 32'h0,        32'h0,        1'b0};
    vecs[7]  = '{1, 1'b0, 2'b01, 32'h6, 32'h0,        32'h000001C0, 1'b0};
    vecs[8]  = '{0, 1'b0, 2'b00, 32'h7, 32'h0,        32'h00000001, 1'b0};
    vecs[9]  = '{1, 1'b0, 2'b11, 32'h8, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{0, 1'b0, 2'b01, 32'h5, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1, 1'b0, 2'b10, 32'h6, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1, 1'b1, 2'b00, 32'h9, 32'h000000AB, 32'h0,        1'b0};
    vecs[13] = '{0, 1'b0, 2'b10, 32'h8, 32'h0,        32'h0000AB00, 1'b0};

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    for (int unsigned i = 0; i < 256; i++) mem[i] = 8'h00;
    req_valid = '0; req_we = '0; rsp_ready = '1;
    for (int unsigned p = 0; p < 2; p++) begin
      req_mode[p] = '0; req_addr[p] = '0; req_wdata[p] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {26'h0, mem_we, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                          rsp0_err | rsp1_err} | mem_addr | mem_wdata | rsp0_rdata | rsp1_rdata,
          32'd0);
    rst_n = 1'b1;

    // Both ports request continuously from reset.
    @(negedge clk);
    drive(0, 1'b0, 2'b10, 32'h4, 32'h0);
    drive(1, 1'b0, 2'b00, 32'h4, 32'h0);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      int cyc = 0;
      #1;
      while (!(req0_ready || req1_ready) && cyc < 20) begin
        @(negedge clk); #1; cyc++;
      end
      check("tie_any_ready", 32'(req0_ready | req1_ready), 32'd1);
      check("tie_onehot", 32'(req0_ready & req1_ready), 32'd0);
      g = req1_ready ? 1 : 0;
      check($sformatf("tie_grant%0d", k), 32'(g), 32'(exp_g[k]));
      if (k > 0) check("tie_spacing", 32'(int'(cycle) - prev), 32'd3);
      prev = int'(cycle);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = '0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 14; i++) run_txn(vecs[i], i);

    // Response stall on port 0 with port 1 waiting.
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    drive(0, 1'b0, 2'b10, 32'h4, 32'h0);
    wait_ready(0, seen);
    check("stall_accept", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    drive(1, 1'b0, 2'b00, 32'h4, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(rsp0_valid), 32'd1);
      check("stall_rdata", rsp0_rdata, 32'h01C00F93);
      check("stall_err", 32'(rsp0_err), 32'd0);
      check("stall_req1_ready", 32'(req1_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("release_req1_ready", 32'(req1_ready), 32'd1);
    check("release_rsp0_done", 32'(rsp0_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("release_rsp1", rsp1_rdata, 32'h00000093);
    repeat (2) @(negedge clk);

    // Reset during ACCESS of a store.
    drive(0, 1'b1, 2'b10, 32'h4, 32'hDEADBEEF);
    wait_ready(0, seen);
    check("rstacc_accept", 32'(seen), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("rstacc_we_before", 32'(mem_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstacc_we_dropped", 32'(mem_we), 32'd0);
    check("rstacc_addr_zero", mem_addr, 32'd0);
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    check("rstacc_mem_kept", {mem[7], mem[6], mem[5], mem[4]}, 32'h01C00F93);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstacc_no_rsp", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    drive(0, 1'b0, 2'b10, 32'h4, 32'h0);
    drive(1, 1'b0, 2'b10, 32'h4, 32'h0);
    #1;
    check("rstacc_tie", 32'({req1_ready, req0_ready}), 32'd1);
    req_valid = '0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
